// File: rtl/util_axis_1553_string_pkg.sv
// Shared constants for the 1553 word-to-text encoder: ASCII codes, word
// type codes, the four-character type labels and the line length.
package util_axis_1553_string_pkg;

  localparam int LINE_BYTES = 22;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_ONE   = 8'h31;
  localparam logic [7:0] ASCII_UP_A  = 8'h41;
  localparam logic [7:0] ASCII_X     = 8'h78;
  localparam logic [7:0] ASCII_U     = 8'h55;
  localparam logic [7:0] ASCII_EQ    = 8'h3D;
  localparam logic [7:0] ASCII_P     = 8'h50;

  localparam logic [2:0] TYPE_CMDS = 3'b100;
  localparam logic [2:0] TYPE_DATA = 3'b010;

  localparam logic [31:0] STR_CMDS = "CMDS";
  localparam logic [31:0] STR_DATA = "DATA";
  localparam logic [31:0] STR_UNKN = "UNKN";

  // Map the decoder word-type field onto its printed label.
  function automatic logic [31:0] type_label(input logic [2:0] word_type);
    case (word_type)
      TYPE_CMDS: type_label = STR_CMDS;
      TYPE_DATA: type_label = STR_DATA;
      default:   type_label = STR_UNKN;
    endcase
  endfunction

endpackage

// File: rtl/util_nibble_to_ascii.sv
// Converts one 4-bit nibble into its uppercase hexadecimal ASCII character.
module util_nibble_to_ascii
  import util_axis_1553_string_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  // Digits 0-9 map onto '0'..'9', 10-15 onto 'A'..'F'.
  always_comb begin
    ascii = ASCII_ZERO + {4'h0, nibble};
    if (nibble > 4'd9) begin
      ascii = ASCII_UP_A + {4'h0, nibble} - 8'd10;
    end
  end

endmodule

// File: rtl/util_axis_1553_string_encoder.sv
// Formats one decoded 1553 word plus its side-band into a fixed 22-character
// ASCII line and presents the whole line as a single AXI-Stream beat. A single
// output register gives one cycle of latency and full throughput when the
// downstream side keeps ready high.
module util_axis_1553_string_encoder
  import util_axis_1553_string_pkg::*;
(
  input  logic                      aclk,
  input  logic                      arstn,
  input  logic [15:0]               s_axis_tdata,
  input  logic [7:0]                s_axis_tuser,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  output logic [LINE_BYTES*8-1:0]   m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready
);

  logic [3:0]              nibbles [6];
  logic [7:0]              hex_chars [6];
  logic [7:0]              parity_char;
  logic [LINE_BYTES*8-1:0] line;
  logic                    accept;

  // Nibbles 0-3 are the data word (most significant first), 4-5 the side-band.
  assign nibbles[0] = s_axis_tdata[15:12];
  assign nibbles[1] = s_axis_tdata[11:8];
  assign nibbles[2] = s_axis_tdata[7:4];
  assign nibbles[3] = s_axis_tdata[3:0];
  assign nibbles[4] = s_axis_tuser[7:4];
  assign nibbles[5] = s_axis_tuser[3:0];

  for (genvar i = 0; i < 6; i++) begin : g_hex
    util_nibble_to_ascii u_hex (
      .nibble (nibbles[i]),
      .ascii  (hex_chars[i])
    );
  end

  // 1553 uses odd parity, so the parity bit is set when the data has an even
  // number of ones.
  assign parity_char = (^s_axis_tdata) ? ASCII_ZERO : ASCII_ONE;

  assign line = {type_label(s_axis_tuser[7:5]),
                 ASCII_SPACE, ASCII_ZERO, ASCII_X,
                 hex_chars[0], hex_chars[1], hex_chars[2], hex_chars[3],
                 ASCII_SPACE, ASCII_U, ASCII_EQ,
                 hex_chars[4], hex_chars[5],
                 ASCII_SPACE, ASCII_P, ASCII_EQ,
                 parity_char, ASCII_CR, ASCII_LF};

  // The slot can take a new word when it is empty or being drained this cycle.
  assign s_axis_tready = arstn & (~m_axis_tvalid | m_axis_tready);
  assign accept        = s_axis_tvalid & s_axis_tready;

  // Output register: load on accept, clear valid once the line is taken.
  always_ff @(posedge aclk) begin
    if (!arstn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
    end else if (accept) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= line;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_util_axis_1553_string_encoder.sv
// Randomized and directed bench for the 1553 string encoder. Expected lines
// are built as text strings from the line format and queued in order.
module tb_util_axis_1553_string_encoder;

  logic         tb_data_clk;
  logic         arstn;
  logic [15:0]  s_axis_tdata;
  logic [7:0]   s_axis_tuser;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic [175:0] m_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tready;

  int           err_count   = 0;
  int           check_count = 0;
  logic [175:0] exp_queue [$];
  bit           last_acc    = 0;
  bit           stall_prev  = 0;
  logic [175:0] data_prev   = '0;

  util_axis_1553_string_encoder dut (
    .aclk          (tb_data_clk),
    .arstn         (arstn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready)
  );

  // Free-running stream clock.
  initial begin
    tb_data_clk = 1'b0;
    forever #5 tb_data_clk = ~tb_data_clk;
  end

  // Hard stop in case the sequence ever stops advancing.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [175:0] str2line(input string s);
    logic [175:0] r;
    r = '0;
    for (int i = 0; i < 22; i++) begin
      if (i < s.len()) r[175-8*i -: 8] = s[i];
    end
    return r;
  endfunction

  function automatic logic [175:0] modelLine(input logic [15:0] d, input logic [7:0] u);
    string typ, hx, ux, pc, s;
    if (u[7:5] == 3'b100)      typ = "CMDS";
    else if (u[7:5] == 3'b010) typ = "DATA";
    else                       typ = "UNKN";
    hx = $sformatf("%04h", d);
    hx = hx.toupper();
    ux = $sformatf("%02h", u);
    ux = ux.toupper();
    pc = ($countones(d) % 2 == 0) ? "1" : "0";
    s = {typ, " 0x", hx, " U=", ux, " P=", pc, "\r\n"};
    return str2line(s);
  endfunction

  task automatic checkOutput(input string tag, input logic [175:0] obs, input logic [175:0] exp);
    check_count++;
    if (obs !== exp) begin
      err_count++;
      $display("[TB] FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, then score what the
  // upcoming rising edge will transfer.
  task automatic applyStimulus(input logic rst_n, input logic tv, input logic [15:0] td,
                               input logic [7:0] tu, input logic mr);
    logic [175:0] exp_line;
    @(negedge tb_data_clk);
    arstn         = rst_n;
    s_axis_tvalid = tv;
    s_axis_tdata  = td;
    s_axis_tuser  = tu;
    m_axis_tready = mr;
    #1;
    if (stall_prev) begin
      checkOutput("stall_valid", 176'(m_axis_tvalid), 176'(1'b1));
      checkOutput("stall_data", m_axis_tdata, data_prev);
    end
    if (arstn && m_axis_tvalid && m_axis_tready) begin
      checkOutput("sb_pending", 176'(exp_queue.size() != 0), 176'(1'b1));
      if (exp_queue.size() != 0) begin
        exp_line = exp_queue.pop_front();
        checkOutput("sb_line", m_axis_tdata, exp_line);
      end
    end
    last_acc = tv && s_axis_tready;
    if (last_acc) exp_queue.push_back(modelLine(td, tu));
    stall_prev = arstn && m_axis_tvalid && !m_axis_tready;
    data_prev  = m_axis_tdata;
    if (!arstn) exp_queue.delete();
  endtask

  initial begin
    logic [15:0] d;
    logic [7:0]  u;
    bit          prev_acc;

    arstn = 1'b0; s_axis_tvalid = 1'b0; s_axis_tdata = '0;
    s_axis_tuser = '0; m_axis_tready = 1'b0;

    // Reset held for four cycles with traffic offered.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, 16'h1234, 8'h80, 1'b1);
      checkOutput("rst_s_tready", 176'(s_axis_tready), 176'(1'b0));
      checkOutput("rst_m_tvalid", 176'(m_axis_tvalid), 176'(1'b0));
      checkOutput("rst_m_tdata", m_axis_tdata, '0);
    end
    applyStimulus(1'b1, 1'b0, 16'h0, 8'h0, 1'b1);
    checkOutput("post_rst_s_tready", 176'(s_axis_tready), 176'(1'b1));

    // Directed lines from the format examples.
    applyStimulus(1'b1, 1'b1, 16'h0000, 8'h07, 1'b1);
    applyStimulus(1'b1, 1'b1, 16'hABCD, 8'h80, 1'b1);
    checkOutput("dir_unkn", m_axis_tdata, str2line("UNKN 0x0000 U=07 P=1\r\n"));
    applyStimulus(1'b1, 1'b1, 16'h0001, 8'h40, 1'b1);
    checkOutput("dir_cmds", m_axis_tdata, str2line("CMDS 0xABCD U=80 P=1\r\n"));
    applyStimulus(1'b1, 1'b0, 16'h0, 8'h0, 1'b1);
    checkOutput("dir_data", m_axis_tdata, str2line("DATA 0x0001 U=40 P=0\r\n"));

    // Continuous incrementing input against random downstream ready.
    d = 16'h1000;
    u = 8'h01;
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b1, 1'b1, d, u, 1'($urandom % 2));
      if (last_acc) begin
        d = d + 16'd1;
        u = {u[6:0], u[7]};
      end
    end

    // Back-to-back random words with ready held: no bubbles.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 1'b1, 16'($urandom), 8'($urandom), 1'b1);
      if (i > 0) checkOutput("nobubble", 176'(m_axis_tvalid), 176'(1'b1));
    end

    // Input valid toggling: only valid cycles produce lines.
    for (int i = 0; i < 20; i++) begin
      prev_acc = last_acc;
      applyStimulus(1'b1, 1'(i % 2), 16'($urandom), 8'($urandom), 1'b1);
      checkOutput("toggle_valid", 176'(m_axis_tvalid), 176'(prev_acc));
    end

    // Stall with a full output, then release and accept in the same cycle.
    applyStimulus(1'b1, 1'b0, 16'h0, 8'h0, 1'b1);
    applyStimulus(1'b1, 1'b0, 16'h0, 8'h0, 1'b1);
    applyStimulus(1'b1, 1'b1, 16'hBEEF, 8'h5A, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b1, 16'hC0DE, 8'h9F, 1'b0);
      checkOutput("stall_s_tready", 176'(s_axis_tready), 176'(1'b0));
    end
    applyStimulus(1'b1, 1'b1, 16'hC0DE, 8'h9F, 1'b1);
    checkOutput("release_accept", 176'(s_axis_tready), 176'(1'b1));
    applyStimulus(1'b1, 1'b0, 16'h0, 8'h0, 1'b1);
    checkOutput("release_next", m_axis_tdata, modelLine(16'hC0DE, 8'h9F));

    // Reset in the middle of a stalled line drops it.
    applyStimulus(1'b1, 1'b1, 16'h5555, 8'h47, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'h0, 8'h0, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h7777, 8'h80, 1'b0);
    checkOutput("midrst_s_tready", 176'(s_axis_tready), 176'(1'b0));
    applyStimulus(1'b1, 1'b0, 16'h0, 8'h0, 1'b1);
    checkOutput("midrst_drop", 176'(m_axis_tvalid), 176'(1'b0));

    // Drain and confirm every queued line was delivered.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 16'h0, 8'h0, 1'b1);
    checkOutput("sb_drained", 176'(exp_queue.size()), 176'(0));

    $display("Result: errors=%0d of %0d checks", err_count, check_count);
    $finish;
  end

endmodule
